// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit bridging execute to the ram second port, with alignment
// checks, store-cycle tracking, load extension and a stall (busy) output.
module lsu_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [1:0]  reqMode,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        busy,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        fault,
  output logic        port2en,
  output logic        wrEn,
  output logic [31:0] port2adr,
  output logic [31:0] port2i,
  output logic [1:0]  memMode,
  input  logic [31:0] port2o,
  input  logic        port2avail,
  input  logic        iRegAvail
);
  typedef enum logic [2:0] {IDLE, ISSUE, LOAD_WAIT, ST_WAIT1, ST_WAIT2} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic sgn_q, sgn_d, busy_q, busy_d, resp_valid_q, resp_valid_d, fault_q, fault_d;
  logic port2en_q, port2en_d, wr_en_q, wr_en_d;
  logic [31:0] resp_data_q, resp_data_d, adr_q, adr_d, wdata_q, wdata_d, ext;
  logic [1:0] mode_q, mode_d;
  logic bad, expired;
  assign bad = (reqMode == 2'd3) | (reqMode == 2'd0 & |reqAddr[1:0]) | (reqMode == 2'd1 & reqAddr[0]);
  assign cnt_inc = cnt_q + 4'd1;
  assign expired = cnt_inc == 4'(TIMEOUT);
  assign ext = mode_q == 2'd2 ? {{24{sgn_q & port2o[7]}}, port2o[7:0]} :
               mode_q == 2'd1 ? {{16{sgn_q & port2o[15]}}, port2o[15:0]} : port2o;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    port2en_d = port2en_q;
    wr_en_d = wr_en_q;
    adr_d = adr_q;
    wdata_d = wdata_q;
    mode_d = mode_q;
    resp_valid_d = 1'b0;
    fault_d = 1'b0;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: if (reqValid) begin
        adr_d = reqAddr;
        wdata_d = reqData;
        mode_d = reqMode;
        sgn_d = reqSigned;
        if (bad) begin
          resp_valid_d = 1'b1;
          fault_d = 1'b1;
          resp_data_d = '0;
        end else begin
          state_d = ISSUE;
          port2en_d = 1'b1;
          wr_en_d = reqWrite;
          cnt_d = '0;
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        if (iRegAvail) begin
          state_d = wr_en_q ? ST_WAIT1 : LOAD_WAIT;
          port2en_d = 1'b0;
          wr_en_d = 1'b0;
        end else if (expired) begin
          state_d = IDLE;
          port2en_d = 1'b0;
          wr_en_d = 1'b0;
          resp_valid_d = 1'b1;
          fault_d = 1'b1;
          resp_data_d = '0;
        end
      end
      LOAD_WAIT: begin
        cnt_d = cnt_inc;
        if (port2avail | expired) begin
          state_d = IDLE;
          resp_valid_d = 1'b1;
          fault_d = ~port2avail;
          resp_data_d = port2avail ? ext : '0;
        end
      end
      ST_WAIT1: state_d = ST_WAIT2;
      ST_WAIT2: begin
        state_d = IDLE;
        resp_valid_d = 1'b1;
        resp_data_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      busy_q <= 1'b0;
      resp_valid_q <= 1'b0;
      fault_q <= 1'b0;
      port2en_q <= 1'b0;
      wr_en_q <= 1'b0;
      resp_data_q <= '0;
      adr_q <= '0;
      wdata_q <= '0;
      mode_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      busy_q <= busy_d;
      resp_valid_q <= resp_valid_d;
      fault_q <= fault_d;
      port2en_q <= port2en_d;
      wr_en_q <= wr_en_d;
      resp_data_q <= resp_data_d;
      adr_q <= adr_d;
      wdata_q <= wdata_d;
      mode_q <= mode_d;
    end
  end
  assign busy = busy_q;
  assign respValid = resp_valid_q;
  assign respData = resp_data_q;
  assign fault = fault_q;
  assign port2en = port2en_q;
  assign wrEn = wr_en_q;
  assign port2adr = adr_q;
  assign port2i = wdata_q;
  assign memMode = mode_q;
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed checks of lsu_unit against a small behavioural ram port2 model.
module tb_lsu_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic reqValid = 1'b0, reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0] reqMode = '0;
  logic [31:0] reqAddr = '0, reqData = '0;
  logic busy, respValid, fault, port2en, wrEn;
  logic [31:0] respData, port2adr, port2i;
  logic [1:0] memMode;
  logic [31:0] port2o;
  logic port2avail, iRegAvail;
  logic ram_ok = 1'b1;
  logic [31:0] mem [0:255];
  int rs;
  int checks = 0, errors = 0;

  lsu_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqWrite(reqWrite), .reqMode(reqMode),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData), .busy(busy),
    .respValid(respValid), .respData(respData), .fault(fault), .port2en(port2en),
    .wrEn(wrEn), .port2adr(port2adr), .port2i(port2i), .memMode(memMode),
    .port2o(port2o), .port2avail(port2avail), .iRegAvail(iRegAvail)
  );

  always #5 clk = ~clk;

  // ram model: load data one cycle after the take, store rewrite two cycles after
  assign iRegAvail = ram_ok && rs == 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rs <= 0;
      port2avail <= 1'b0;
      port2o <= '0;
    end else begin
      case (rs)
        0: if (port2en && iRegAvail) begin
          if (wrEn) rs <= 2;
          else begin
            rs <= 1;
            port2avail <= 1'b1;
            port2o <= mem[port2adr[9:2]] >> {port2adr[1:0], 3'b000};
          end
        end
        1: begin
          rs <= 0;
          port2avail <= 1'b0;
        end
        2: rs <= 3;
        default: begin
          rs <= 0;
          case (memMode)
            2'd2: mem[port2adr[9:2]][{port2adr[1:0], 3'b000} +: 8] <= port2i[7:0];
            2'd1: mem[port2adr[9:2]][{port2adr[1:0], 3'b000} +: 16] <= port2i[15:0];
            default: mem[port2adr[9:2]] <= port2i;
          endcase
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [1:0] m, input logic s, input logic [31:0] a, input logic [31:0] d);
    reqValid = 1'b1;
    reqWrite = w;
    reqMode = m;
    reqSigned = s;
    reqAddr = a;
    reqData = d;
  endtask

  task automatic do_load(input string tag, input logic [1:0] m, input logic s, input logic [31:0] a, input logic [31:0] exp);
    req(1'b0, m, s, a, 32'h0);
    step();
    reqValid = 1'b0;
    chk({tag, "_c1_busy"}, {31'b0, busy}, 1);
    chk({tag, "_c1_en"}, {31'b0, port2en}, 1);
    chk({tag, "_c1_adr"}, port2adr, a);
    step();
    chk({tag, "_c2_rv"}, {31'b0, respValid}, 0);
    step();
    chk({tag, "_c3_rv"}, {31'b0, respValid}, 1);
    chk({tag, "_c3_data"}, respData, exp);
    chk({tag, "_c3_fault"}, {31'b0, fault}, 0);
    chk({tag, "_c3_busy"}, {31'b0, busy}, 0);
  endtask

  task automatic do_store(input string tag, input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
    req(1'b1, m, 1'b0, a, d);
    step();
    reqValid = 1'b0;
    chk({tag, "_c1_en"}, {30'b0, port2en, wrEn}, 3);
    chk({tag, "_c1_mode"}, {30'b0, memMode}, {30'b0, m});
    step();
    chk({tag, "_c2_en"}, {30'b0, port2en, wrEn}, 0);
    step();
    chk({tag, "_c3_rv"}, {31'b0, respValid}, 0);
    step();
    chk({tag, "_c4_rv"}, {31'b0, respValid}, 1);
    chk({tag, "_c4_fault_data"}, {fault, respData[30:0]}, 0);
  endtask

  task automatic do_fault(input string tag, input logic [1:0] m, input logic [31:0] a);
    req(1'b0, m, 1'b0, a, 32'h0);
    step();
    reqValid = 1'b0;
    chk({tag, "_rv_fault"}, {30'b0, respValid, fault}, 3);
    chk({tag, "_busy_en"}, {30'b0, busy, port2en}, 0);
    chk({tag, "_data"}, respData, 0);
    step();
    chk({tag, "_rv_after"}, {30'b0, respValid, port2en}, 0);
  endtask

  initial begin
    int en_cycles;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8899AABB;
    step();
    step();
    chk("reset_outs", {26'b0, busy, respValid, fault, port2en, wrEn, 1'b0}, 0);
    chk("reset_adr_mode", {port2adr[29:0], memMode}, 0);
    reset = 1'b0;
    step();
    do_load("lw", 2'd0, 1'b0, 32'h100, 32'h8899AABB);
    do_load("lbs", 2'd2, 1'b1, 32'h103, 32'hFFFFFF88);
    do_load("lbu", 2'd2, 1'b0, 32'h103, 32'h00000088);
    do_load("lhs", 2'd1, 1'b1, 32'h102, 32'hFFFF8899);
    do_load("lhu", 2'd1, 1'b0, 32'h100, 32'h0000AABB);
    step();
    do_store("sb", 2'd2, 32'h101, 32'h1234565A);
    do_load("lw_after_sb", 2'd0, 1'b0, 32'h100, 32'h88995ABB);
    step();
    do_fault("mis_w", 2'd0, 32'h102);
    do_fault("mis_h", 2'd1, 32'h101);
    do_fault("mode3", 2'd3, 32'h100);
    ram_ok = 1'b0;
    req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    step();
    reqValid = 1'b0;
    en_cycles = 0;
    for (int i = 0; i < 40 && !respValid; i++) begin
      if (port2en) en_cycles++;
      step();
    end
    chk("to_en_cycles", en_cycles, 15);
    chk("to_rv_fault", {30'b0, respValid, fault}, 3);
    chk("to_en_busy", {30'b0, port2en, busy}, 0);
    chk("to_data", respData, 0);
    ram_ok = 1'b1;
    step();
    chk("to_rv_after", {31'b0, respValid}, 0);
    req(1'b1, 2'd0, 1'b0, 32'h100, 32'h77777777);
    step();
    reqValid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {27'b0, busy, respValid, fault, port2en, wrEn}, 0);
    chk("rst_mid_adr", port2adr, 0);
    chk("rst_mid_data", {port2i[29:0], memMode}, 0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("rst_no_resp", {31'b0, respValid}, 0);
    do_load("lw_after_rst", 2'd0, 1'b0, 32'h100, 32'h88995ABB);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
